// File: rtl/rs_pkg.sv
//==========================================================================
// rs_pkg : shared limits and helpers for the RS GF(2^M) lookup blocks
// Rev 1.0
//==========================================================================
`default_nettype none

package rs_pkg;

  localparam int M_MIN    = 3;
  localparam int M_MAX    = 8;
  localparam int NREQ_MAX = 8;
  localparam int IDX_W    = 3;
  localparam int TBL_W    = (1 << M_MAX) * M_MAX;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ_MAX; i++)
      if (oh[i]) r = r | IDX_W'(i);
    return r;
  endfunction

  function automatic logic [M_MAX:0] gf_poly(input int m);
    case (m)
      3:       return 9'h00B;
      4:       return 9'h013;
      5:       return 9'h025;
      6:       return 9'h043;
      7:       return 9'h089;
      default: return 9'h11D;
    endcase
  endfunction

  // Entry i (8-bit slot) holds alpha^i; entry 2^m-1 wraps back to 1.
  function automatic logic [TBL_W-1:0] gf_exp_tbl(input int m);
    logic [TBL_W-1:0] t;
    logic [M_MAX:0]   a;
    logic [M_MAX:0]   poly;
    t    = '0;
    a    = 9'd1;
    poly = gf_poly(m);
    for (int i = 0; i < (1 << m); i++) begin
      t[i*M_MAX +: M_MAX] = a[M_MAX-1:0];
      a = a << 1;
      if (a[m]) a = a ^ poly;
    end
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_exp_lut_arb_lut.sv
//==========================================================================
// idx2gfN : combinational index -> GF(2^M) element tables, M = 3..8
// Rev 1.0
//==========================================================================
`default_nettype none

module idx2gf8
  import rs_pkg::*;
(
  input  logic [2:0] idx,
  output logic [2:0] z
);
  localparam logic [TBL_W-1:0] TBL = gf_exp_tbl(3);
  logic [7:0] w_idx;
  assign w_idx = 8'(idx);
  assign z     = TBL[{w_idx, 3'b000} +: 3];
endmodule

module idx2gf16
  import rs_pkg::*;
(
  input  logic [3:0] idx,
  output logic [3:0] z
);
  localparam logic [TBL_W-1:0] TBL = gf_exp_tbl(4);
  logic [7:0] w_idx;
  assign w_idx = 8'(idx);
  assign z     = TBL[{w_idx, 3'b000} +: 4];
endmodule

module idx2gf32
  import rs_pkg::*;
(
  input  logic [4:0] idx,
  output logic [4:0] z
);
  localparam logic [TBL_W-1:0] TBL = gf_exp_tbl(5);
  logic [7:0] w_idx;
  assign w_idx = 8'(idx);
  assign z     = TBL[{w_idx, 3'b000} +: 5];
endmodule

module idx2gf64
  import rs_pkg::*;
(
  input  logic [5:0] idx,
  output logic [5:0] z
);
  localparam logic [TBL_W-1:0] TBL = gf_exp_tbl(6);
  logic [7:0] w_idx;
  assign w_idx = 8'(idx);
  assign z     = TBL[{w_idx, 3'b000} +: 6];
endmodule

module idx2gf128
  import rs_pkg::*;
(
  input  logic [6:0] idx,
  output logic [6:0] z
);
  localparam logic [TBL_W-1:0] TBL = gf_exp_tbl(7);
  logic [7:0] w_idx;
  assign w_idx = 8'(idx);
  assign z     = TBL[{w_idx, 3'b000} +: 7];
endmodule

module idx2gf256
  import rs_pkg::*;
(
  input  logic [7:0] idx,
  output logic [7:0] z
);
  localparam logic [TBL_W-1:0] TBL = gf_exp_tbl(8);
  assign z = TBL[{idx, 3'b000} +: 8];
endmodule

`default_nettype wire

// File: rtl/rs_exp_lut_arb.sv
//==========================================================================
// rs_exp_lut_arb : round-robin arbitrated GF(2^M) exp lookup, 1-cycle latency
// Rev 1.0
//==========================================================================
`default_nettype none

module rs_exp_lut_arb
  import rs_pkg::*;
#(
  parameter int M    = 8,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ*M-1:0] req_idx,
  output logic [NREQ-1:0]   req_rdy,
  output logic              rsp_vld,
  output logic [NREQ-1:0]   rsp_id,
  output logic [M-1:0]      rsp_z,
  input  logic              rsp_rdy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    r_ptr;
  logic             r_vld;
  logic [NREQ-1:0]  r_id;
  logic [M-1:0]     r_z;

  logic             w_free;
  logic             w_acc;
  logic [NREQ-1:0]  w_gnt;
  logic [M-1:0]     w_sel_idx;
  logic [M-1:0]     w_lut_z;
  logic [IDX_W-1:0] w_win;
  logic [IDX_W-1:0] w_ptr_nxt;

  // rst_n gates the grant so req_rdy stays low for the whole reset window.
  assign w_free = rst_n & (~r_vld | rsp_rdy);

  // Two passes: requesters at/after ptr first, then the wrapped-around ones.
  always_comb begin
    w_gnt = '0;
    w_acc = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_free && !w_acc && req_vld[i] && (i >= int'(r_ptr))) begin
        w_gnt[i] = 1'b1;
        w_acc    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_free && !w_acc && req_vld[i]) begin
        w_gnt[i] = 1'b1;
        w_acc    = 1'b1;
      end
    end
  end

  // Non-granted indices are never read, so X there cannot reach the LUT.
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) w_sel_idx = w_sel_idx | req_idx[i*M +: M];
  end

  assign w_win     = onehot_to_idx(NREQ_MAX'(w_gnt));
  assign w_ptr_nxt = (w_win == IDX_W'(NREQ-1)) ? '0 : w_win + 1'b1;

  if (M == M_MIN) begin : g_gf8
    idx2gf8   u_lut (.idx(w_sel_idx), .z(w_lut_z));
  end else if (M == 4) begin : g_gf16
    idx2gf16  u_lut (.idx(w_sel_idx), .z(w_lut_z));
  end else if (M == 5) begin : g_gf32
    idx2gf32  u_lut (.idx(w_sel_idx), .z(w_lut_z));
  end else if (M == 6) begin : g_gf64
    idx2gf64  u_lut (.idx(w_sel_idx), .z(w_lut_z));
  end else if (M == 7) begin : g_gf128
    idx2gf128 u_lut (.idx(w_sel_idx), .z(w_lut_z));
  end else if (M == M_MAX) begin : g_gf256
    idx2gf256 u_lut (.idx(w_sel_idx), .z(w_lut_z));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_id  <= '0;
      r_z   <= '0;
      r_ptr <= '0;
    end else if (w_acc) begin
      r_vld <= 1'b1;
      r_id  <= w_gnt;
      r_z   <= w_lut_z;
      r_ptr <= PW'(w_ptr_nxt);
    end else if (r_vld && rsp_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign req_rdy = w_gnt;
  assign rsp_vld = r_vld;
  assign rsp_id  = r_id;
  assign rsp_z   = r_z;

endmodule

`default_nettype wire

// File: tb/tb_rs_exp_lut_arb.sv
//==========================================================================
// tb_rs_exp_lut_arb : directed + random bench with a round-robin/GF reference
// Rev 1.0
//==========================================================================
`default_nettype none

module tb_rs_exp_lut_arb;

  localparam int M    = 8;
  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_vld;
  logic [NREQ*M-1:0] req_idx;
  logic [NREQ-1:0]   req_rdy;
  logic              rsp_vld;
  logic [NREQ-1:0]   rsp_id;
  logic [M-1:0]      rsp_z;
  logic              rsp_rdy;

  logic [NREQ-1:0]   req_vld_4;
  logic [NREQ*4-1:0] req_idx_4;
  logic [NREQ-1:0]   req_rdy_4;
  logic              rsp_vld_4;
  logic [NREQ-1:0]   rsp_id_4;
  logic [3:0]        rsp_z_4;
  logic              rsp_rdy_4;

  int checks   = 0;
  int failures = 0;

  int m_ptr;
  bit m_vld;
  int m_id;
  int m_z;

  int tbl16 [16] = '{1, 2, 4, 8, 3, 6, 12, 11, 5, 10, 7, 14, 15, 13, 9, 1};

  rs_exp_lut_arb #(.M(M), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_idx(req_idx),
    .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_rdy(rsp_rdy)
  );

  rs_exp_lut_arb #(.M(4), .NREQ(NREQ)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld_4), .req_idx(req_idx_4),
    .req_rdy(req_rdy_4), .rsp_vld(rsp_vld_4), .rsp_id(rsp_id_4), .rsp_z(rsp_z_4),
    .rsp_rdy(rsp_rdy_4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // alpha^idx by repeated doubling modulo the field polynomial
  function automatic int gf_exp_ref(input int m, input int idx);
    int a    = 1;
    int poly = (m == 8) ? 'h11D : 'h13;
    for (int k = 0; k < idx; k++) begin
      a = a << 1;
      if (a >= (1 << m)) a = a ^ poly;
    end
    return a;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the current inputs: check grant, advance model, check response.
  task automatic step(input string tag);
    int g;
    #1;
    g = (rst_n && (!m_vld || rsp_rdy)) ? rr_pick(m_ptr, req_vld) : -1;
    chk({tag, ":req_rdy"}, 32'(req_rdy), (g < 0) ? 32'd0 : 32'(1 << g));
    @(posedge clk);
    if (g >= 0) begin
      m_vld = 1'b1;
      m_id  = 1 << g;
      m_z   = gf_exp_ref(M, int'(req_idx[g*M +: M]));
      m_ptr = (g + 1) % NREQ;
    end else if (m_vld && rsp_rdy) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
    chk({tag, ":rsp_vld"}, 32'(rsp_vld), 32'(m_vld));
    if (m_vld) begin
      chk({tag, ":rsp_id"}, 32'(rsp_id), 32'(m_id));
      chk({tag, ":rsp_z"},  32'(rsp_z),  32'(m_z));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_vld   = '1;
    req_idx   = '0;
    rsp_rdy   = 1'b1;
    req_vld_4 = '0;
    req_idx_4 = '0;
    rsp_rdy_4 = 1'b0;
    m_ptr = 0; m_vld = 1'b0; m_id = 0; m_z = 0;

    repeat (2) @(negedge clk);
    chk("reset:rsp_vld", 32'(rsp_vld), 32'd0);
    chk("reset:rsp_id",  32'(rsp_id),  32'd0);
    chk("reset:rsp_z",   32'(rsp_z),   32'd0);
    chk("reset:req_rdy", 32'(req_rdy), 32'd0);
    rst_n   = 1'b1;
    req_vld = '0;

    step("idle");

    // Full contention from ptr 0: grants rotate 0,1,2,0,1,2.
    req_vld = 3'b111;
    for (int k = 0; k < 6; k++) begin
      req_idx = NREQ*M'({$urandom, $urandom});
      step("contend");
      chk("contend:order", 32'(rsp_id), 32'(1 << (k % 3)));
    end
    req_vld = '0;
    step("drain0");

    req_vld = 3'b001;
    req_idx = '0;
    req_idx[0 +: M] = 8'd8;
    step("single");
    chk("single:z",  32'(rsp_z),  32'd29);
    chk("single:id", 32'(rsp_id), 32'b001);
    req_vld = '0;
    step("drain1");

    // Backpressure: idx 25 on requester 1, then hold with everyone requesting.
    req_vld = 3'b010;
    req_idx[1*M +: M] = 8'd25;
    step("bp_acc");
    chk("bp_acc:z", 32'(rsp_z), 32'd3);
    rsp_rdy = 1'b0;
    req_vld = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step("bp_hold");
      chk("bp_hold:z",   32'(rsp_z),   32'd3);
      chk("bp_hold:rdy", 32'(req_rdy), 32'd0);
    end
    rsp_rdy = 1'b1;
    step("bp_release");
    chk("bp_release:id", 32'(rsp_id), 32'b100);

    // Wrap: ptr to 2, then only req 0 with idx 255.
    req_vld = 3'b010;
    step("wrap_set");
    req_vld = 3'b001;
    req_idx = '0;
    req_idx[0 +: M] = 8'd255;
    step("wrap_255");
    chk("wrap_255:z",  32'(rsp_z),  32'd1);
    chk("wrap_255:id", 32'(rsp_id), 32'b001);
    req_vld = 3'b111;
    req_idx = '0;
    step("idx0");
    chk("idx0:id", 32'(rsp_id), 32'b010);
    chk("idx0:z",  32'(rsp_z),  32'd1);
    req_vld = '0;
    step("drain2");

    // Random traffic; idle requesters carry X indices.
    for (int n = 0; n < 200; n++) begin
      req_vld = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        req_idx[i*M +: M] = req_vld[i] ? M'($urandom) : 'x;
      rsp_rdy = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // Reset with a held response and ptr 2.
    req_vld = '0;
    req_idx = '0;
    rsp_rdy = 1'b1;
    step("pre_rst_drain");
    req_vld = 3'b010;
    req_idx[1*M +: M] = 8'd77;
    rsp_rdy = 1'b0;
    step("pre_rst_load");
    rst_n   = 1'b0;
    req_vld = 3'b111;
    #1;
    m_vld = 1'b0;
    m_ptr = 0;
    chk("midrst:rsp_vld", 32'(rsp_vld), 32'd0);
    chk("midrst:rsp_id",  32'(rsp_id),  32'd0);
    chk("midrst:rsp_z",   32'(rsp_z),   32'd0);
    chk("midrst:req_rdy", 32'(req_rdy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    req_vld = '0;
    step("post_rst_idle");
    req_vld = 3'b111;
    rsp_rdy = 1'b1;
    step("post_rst_acc");
    chk("post_rst_acc:id", 32'(rsp_id), 32'b001);
    req_vld = '0;

    // M=4 sweep from requester 0.
    req_vld_4 = 3'b001;
    rsp_rdy_4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_idx_4[3:0] = 4'(i);
      @(posedge clk);
      @(negedge clk);
      chk("gf16:vld", 32'(rsp_vld_4), 32'd1);
      chk("gf16:z",   32'(rsp_z_4),   32'(tbl16[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
